// File: rtl/gshare_predictor_pkg.sv
// -----------------------------------------------------------------------------
// gshare_predictor_pkg
// Shared types and helpers for the gshare / bimodal branch direction predictor.
//   BrInfo       : resolved-branch record sent back from execute
//   PredState_t  : predictor sequencer state (INIT clears the table, RUN predicts)
//   sat_update() : saturating up/down step for a counter of up to 4 bits
// -----------------------------------------------------------------------------
package gshare_predictor_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_br;
        logic        taken;
        logic [31:0] pc;
    } BrInfo;

    typedef logic [0:0] PredState_t;
    localparam PredState_t INIT = 1'b0;
    localparam PredState_t RUN  = 1'b1;

    localparam int MAX_CTR_WIDTH = 4;

    // Saturating counter step. The counter is carried at the maximum supported
    // width; 'width' gives the real counter width so the ceiling is correct.
    function automatic logic [3:0] sat_update(input logic [3:0] ctr,
                                              input logic       taken,
                                              input int         width);
        logic [4:0] ceiling;
        ceiling = (5'd1 << width) - 5'd1;
        if (taken) begin
            if (ctr == ceiling[3:0]) sat_update = ctr;
            else                     sat_update = ctr + 4'd1;
        end else begin
            if (ctr == 4'd0)         sat_update = ctr;
            else                     sat_update = ctr - 4'd1;
        end
    endfunction

endpackage

// File: rtl/gshare_predictor_counter_table.sv
// -----------------------------------------------------------------------------
// pred_counter_table
// 2**ADDR_WIDTH x CTR_WIDTH counter storage: two asynchronous read ports (one
// for the fetch lookup, one for the update read-modify-write) and a single
// synchronous write port. There is deliberately no reset on the array so it
// maps onto distributed RAM; the predictor's init sequencer clears it instead.
//   clk      in  : write clock
//   we       in  : write enable
//   waddr    in  : write index
//   wdata    in  : counter value to write
//   raddr_a  in  / rdata_a out : lookup read port
//   raddr_b  in  / rdata_b out : update read port
// -----------------------------------------------------------------------------
module pred_counter_table #(
    parameter int ADDR_WIDTH = 12,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [CTR_WIDTH-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [CTR_WIDTH-1:0]  rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [CTR_WIDTH-1:0]  rdata_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [CTR_WIDTH-1:0] mem [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
// Conditional-branch direction predictor built from saturating counters,
// indexed by PC (bimodal) or PC XOR global history (gshare).
//   clk          in  : clock
//   reset        in  : asynchronous active-high reset; restarts table init
//   pc           in  : fetch address to predict
//   pred_taken   out : combinational prediction for pc (0 until ready)
//   pred_hist    out : current global history register
//   ready        out : table initialised
//   brinfo       in  : resolved instruction from execute
//   brinfo_hist  in  : pred_hist captured when brinfo.pc was predicted
//   hist_flush   in  : clear the global history (wins over a shift)
// Updates are staged one cycle in S and written the cycle after, so a lookup
// sees the new counter two cycles after brinfo is presented.
// -----------------------------------------------------------------------------
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int CTR_WIDTH   = 2,
    parameter int HIST_WIDTH  = 8,
    parameter int USE_GSHARE  = 1,
    parameter int DEFAULT_CTR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    output logic                  pred_taken,
    output logic [HIST_WIDTH-1:0] pred_hist,
    output logic                  ready,
    input  BrInfo                 brinfo,
    input  logic [HIST_WIDTH-1:0] brinfo_hist,
    input  logic                  hist_flush
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0]  DEF_CTR  = CTR_WIDTH'(DEFAULT_CTR);

    // Table index: PC word bits, optionally XORed with history in the low bits.
    function automatic logic [ADDR_WIDTH-1:0] table_index(input logic [31:0]           addr,
                                                          input logic [HIST_WIDTH-1:0] hist);
        logic [ADDR_WIDTH-1:0] hist_ext;
        hist_ext = ADDR_WIDTH'(hist);
        if (USE_GSHARE != 0) table_index = addr[ADDR_WIDTH+1:2] ^ hist_ext;
        else                 table_index = addr[ADDR_WIDTH+1:2];
    endfunction

    PredState_t            state_r;
    logic [ADDR_WIDTH-1:0] init_idx_r;
    logic [HIST_WIDTH-1:0] ghr_r;
    BrInfo                 s_r;
    logic [HIST_WIDTH-1:0] s_hist_r;

    logic [ADDR_WIDTH-1:0] pred_idx_s;
    logic [ADDR_WIDTH-1:0] upd_idx_s;
    logic [CTR_WIDTH-1:0]  pred_ctr_s;
    logic [CTR_WIDTH-1:0]  upd_ctr_s;
    logic [3:0]            sat_s;
    logic                  we_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic [CTR_WIDTH-1:0]  wdata_s;
    logic [HIST_WIDTH:0]   ghr_shift_s;
    logic                  unused_s;

    assign pred_idx_s  = table_index(pc, ghr_r);
    assign upd_idx_s   = table_index(s_r.pc, s_hist_r);
    assign sat_s       = sat_update(MAX_CTR_WIDTH'(upd_ctr_s), s_r.taken, CTR_WIDTH);
    assign ghr_shift_s = {ghr_r, s_r.taken};
    assign unused_s    = ^sat_s;

    pred_counter_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CTR_WIDTH  (CTR_WIDTH)
    ) u_table (
        .clk     (clk),
        .we      (we_s),
        .waddr   (waddr_s),
        .wdata   (wdata_s),
        .raddr_a (pred_idx_s),
        .rdata_a (pred_ctr_s),
        .raddr_b (upd_idx_s),
        .rdata_b (upd_ctr_s)
    );

    // Write-port mux: init clears one entry per cycle, RUN retires the staged update.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = upd_idx_s;
        wdata_s = DEF_CTR;
        if (state_r == INIT) begin
            we_s    = 1'b1;
            waddr_s = init_idx_r;
            wdata_s = DEF_CTR;
        end else if (s_r.valid) begin
            we_s    = 1'b1;
            waddr_s = upd_idx_s;
            if (s_r.is_br) wdata_s = sat_s[CTR_WIDTH-1:0];
            else           wdata_s = DEF_CTR;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Init sequencer and update stage register; S is held invalid during INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= INIT;
            init_idx_r <= {ADDR_WIDTH{1'b0}};
            s_r        <= '0;
            s_hist_r   <= {HIST_WIDTH{1'b0}};
        end else begin
            case (state_r)
                INIT: begin
                    init_idx_r <= init_idx_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    s_r        <= '0;
                    s_hist_r   <= {HIST_WIDTH{1'b0}};
                    if (init_idx_r == LAST_IDX) state_r <= RUN;
                end
                RUN: begin
                    s_r      <= brinfo;
                    s_hist_r <= brinfo_hist;
                end
                default: begin
                    state_r    <= INIT;
                    init_idx_r <= {ADDR_WIDTH{1'b0}};
                    s_r        <= '0;
                end
            endcase
        end
    end

    // Global history: flush wins; otherwise shift in each retired branch outcome.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_r <= {HIST_WIDTH{1'b0}};
        end else if (hist_flush) begin
            ghr_r <= {HIST_WIDTH{1'b0}};
        end else if (state_r == RUN && s_r.valid && s_r.is_br) begin
            ghr_r <= ghr_shift_s[HIST_WIDTH-1:0];
        end
    end

    assign ready      = (state_r == RUN);
    assign pred_taken = ready & pred_ctr_s[CTR_WIDTH-1];
    assign pred_hist  = ghr_r;

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
// Drives a bimodal instance and a gshare instance (ADDR_WIDTH=4, CTR_WIDTH=2,
// HIST_WIDTH=3) with directed steps. A small reference model of each table and
// history register produces expected values, which are queued and then popped
// when the matching DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_b, pc_g;
    logic        pred_b, pred_g;
    logic [2:0]  hist_out_b, hist_out_g;
    logic        ready_b, ready_g;
    BrInfo       br_b, br_g;
    logic [2:0]  hist_b, hist_g;
    logic        flush_b, flush_g;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    int          mb [16];
    int          mg [16];
    logic [2:0]  hb, hg;

    always #5 clk = ~clk;

    gshare_predictor #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(3),
                       .USE_GSHARE(0), .DEFAULT_CTR(0)) dut_b (
        .clk(clk), .reset(reset), .pc(pc_b), .pred_taken(pred_b),
        .pred_hist(hist_out_b), .ready(ready_b), .brinfo(br_b),
        .brinfo_hist(hist_b), .hist_flush(flush_b));

    gshare_predictor #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(3),
                       .USE_GSHARE(1), .DEFAULT_CTR(0)) dut_g (
        .clk(clk), .reset(reset), .pc(pc_g), .pred_taken(pred_g),
        .pred_hist(hist_out_g), .ready(ready_g), .brinfo(br_g),
        .brinfo_hist(hist_g), .hist_flush(flush_g));

    function automatic int idx_of(input bit g, input logic [31:0] a, input logic [2:0] h);
        logic [3:0] ix;
        if (g) ix = a[5:2] ^ {1'b0, h};
        else   ix = a[5:2];
        return int'(ix);
    endfunction

    function automatic int sat(input int c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        else   return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic probe(input bit g, input logic [31:0] a, input string tag);
        @(negedge clk);
        if (g) pc_g = a; else pc_b = a;
        #1;
        if (g) begin
            exp_q.push_back({31'd0, mg[idx_of(1'b1, a, hg)] >= 2});
            chk(tag, {31'd0, pred_g});
        end else begin
            exp_q.push_back({31'd0, mb[idx_of(1'b0, a, hb)] >= 2});
            chk(tag, {31'd0, pred_b});
        end
    endtask

    task automatic probe_hist(input bit g, input string tag);
        @(negedge clk);
        #1;
        if (g) begin
            exp_q.push_back({29'd0, hg});
            chk(tag, {29'd0, hist_out_g});
        end else begin
            exp_q.push_back({29'd0, hb});
            chk(tag, {29'd0, hist_out_b});
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            probe(1'b0, 32'(i * 4), tag);
            probe(1'b1, 32'(i * 4), tag);
        end
    endtask

    // One isolated update; the bimodal path also checks the t+1 lookup sees the old value.
    task automatic send(input bit g, input logic [31:0] a, input logic isb,
                        input logic tk, input logic [2:0] h, input bit fl);
        BrInfo b;
        int    i;
        b.valid = 1'b1; b.is_br = isb; b.taken = tk; b.pc = a;
        @(posedge clk); #1;
        if (g) begin br_g = b; hist_g = h; end else begin br_b = b; hist_b = h; end
        @(posedge clk); #1;
        br_g.valid = 1'b0; br_b.valid = 1'b0;
        if (fl) begin
            if (g) flush_g = 1'b1; else flush_b = 1'b1;
        end
        i = idx_of(g, a, h);
        if (!g) begin
            pc_b = a; #1;
            exp_q.push_back({31'd0, mb[i] >= 2});
            chk("no_bypass", {31'd0, pred_b});
        end
        @(posedge clk); #1;
        flush_g = 1'b0; flush_b = 1'b0;
        if (g) begin
            mg[i] = isb ? sat(mg[i], tk) : 0;
            hg    = fl ? 3'd0 : (isb ? {hg[1:0], tk} : hg);
        end else begin
            mb[i] = isb ? sat(mb[i], tk) : 0;
            hb    = fl ? 3'd0 : (isb ? {hb[1:0], tk} : hb);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(ready_b && ready_g) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        exp_q.push_back(32'd16);
        chk(tag, 32'(n));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mb[i] = 0;
            mg[i] = 0;
        end
        hb = 3'd0;
        hg = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] sat_seq;
        reset = 1'b0;
        pc_b = 32'd0; pc_g = 32'd0;
        br_b = '0; br_g = '0;
        hist_b = 3'd0; hist_g = 3'd0;
        flush_b = 1'b0; flush_g = 1'b0;
        model_clear();

        // Reset state
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(32'd0); chk("rst_ready_b", {31'd0, ready_b});
        exp_q.push_back(32'd0); chk("rst_ready_g", {31'd0, ready_g});
        exp_q.push_back(32'd0); chk("rst_pred_b", {31'd0, pred_b});
        exp_q.push_back(32'd0); chk("rst_pred_g", {31'd0, pred_g});
        exp_q.push_back(32'd0); chk("rst_hist_b", {29'd0, hist_out_b});
        exp_q.push_back(32'd0); chk("rst_hist_g", {29'd0, hist_out_g});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Init sequence: 16 cycles then every entry predicts not-taken
        wait_ready("init_len");
        sweep("init_clear");

        // Bimodal saturation on pc 0x40: T,T,T,T,N,N,N,N,T (LSB first)
        sat_seq = 9'b1_0000_1111;
        for (int k = 0; k < 9; k++) begin
            send(1'b0, 32'h40, 1'b1, sat_seq[k], 3'd0, 1'b0);
            probe(1'b0, 32'h40, "sat_pred");
        end

        // Gshare aliasing: GHR=1, pc 0x44 maps to entry 0
        send(1'b1, 32'h4C, 1'b1, 1'b1, 3'd0, 1'b0);
        probe_hist(1'b1, "ghr_one");
        send(1'b1, 32'h44, 1'b1, 1'b1, 3'd1, 1'b0);
        send(1'b1, 32'h44, 1'b1, 1'b1, 3'd1, 1'b0);
        for (int i = 0; i < 16; i++) probe(1'b1, 32'(i * 4), "gsh_lookup");
        @(posedge clk); #1 flush_g = 1'b1;
        @(posedge clk); #1 flush_g = 1'b0;
        hg = 3'd0;
        probe_hist(1'b1, "flush_only");
        probe(1'b1, 32'h40, "alias_e0");
        probe(1'b1, 32'h44, "alias_e1");

        // Alternating outcomes shift 1, 10, 101
        send(1'b1, 32'h60, 1'b1, 1'b1, hg, 1'b0);
        probe_hist(1'b1, "ghr_alt1");
        send(1'b1, 32'h60, 1'b1, 1'b0, hg, 1'b0);
        probe_hist(1'b1, "ghr_alt2");
        send(1'b1, 32'h60, 1'b1, 1'b1, hg, 1'b0);
        probe_hist(1'b1, "ghr_alt3");

        // Flush in the same cycle as a branch retire
        send(1'b1, 32'h60, 1'b1, 1'b1, hg, 1'b1);
        probe_hist(1'b1, "flush_with_br");
        probe(1'b1, 32'h60, "flush_br_ctr");

        // Non-branch update resets the entry, leaves history alone
        send(1'b1, 32'h50, 1'b1, 1'b1, 3'd0, 1'b0);
        send(1'b1, 32'h50, 1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 16; i++) probe(1'b1, 32'(i * 4), "pre_nonbr");
        send(1'b1, 32'h50, 1'b0, 1'b1, 3'd0, 1'b0);
        probe_hist(1'b1, "nonbr_hist");
        for (int i = 0; i < 16; i++) probe(1'b1, 32'(i * 4), "nonbr_ctr");

        // Back-to-back updates to the same bimodal entry
        @(posedge clk); #1;
        br_b.valid = 1'b1; br_b.is_br = 1'b1; br_b.taken = 1'b1; br_b.pc = 32'h48;
        @(posedge clk); #1;
        @(posedge clk); #1 br_b.valid = 1'b0;
        @(posedge clk); #1;
        mb[2] = sat(sat(mb[2], 1'b1), 1'b1);
        hb = {hb[0], 1'b1, 1'b1};
        probe(1'b0, 32'h48, "b2b_pred");
        probe_hist(1'b0, "b2b_hist");

        // Reset in the middle of back-to-back updates with S valid
        @(posedge clk); #1;
        br_b.valid = 1'b1; br_b.is_br = 1'b1; br_b.taken = 1'b1; br_b.pc = 32'h54;
        br_g.valid = 1'b1; br_g.is_br = 1'b1; br_g.taken = 1'b1; br_g.pc = 32'h54;
        hist_g = 3'd0;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        exp_q.push_back(32'd0); chk("mid_rst_ready_b", {31'd0, ready_b});
        exp_q.push_back(32'd0); chk("mid_rst_ready_g", {31'd0, ready_g});
        exp_q.push_back(32'd0); chk("mid_rst_hist_b", {29'd0, hist_out_b});
        exp_q.push_back(32'd0); chk("mid_rst_hist_g", {29'd0, hist_out_g});
        @(posedge clk); #1;
        br_b.valid = 1'b0; br_g.valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        model_clear();
        wait_ready("reinit_len");
        sweep("reinit_clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
